// File: rtl/tcni_pkg.sv
// Shared types and constants for the TCNI receive path (ejector, packer, bus interface).
package tcni_pkg;

    localparam int FLIT_W    = 16;
    localparam int MEMWORD_W = 32;

    typedef logic [FLIT_W-1:0]    flit_t;
    typedef logic [MEMWORD_W-1:0] memword_t;
    typedef logic [MEMWORD_W-1:0] memoffset_t;

    typedef enum logic [1:0] {
        IDLE,
        SIZE,
        PAYLOAD,
        DONE
    } ej_state_e;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;

    localparam logic [3:0] WB_NONE = 4'b0000;
    localparam logic [3:0] WB_FULL = 4'b1111;
    localparam logic [3:0] WB_LOW  = 4'b0011;

endpackage

// File: rtl/tcni_rx_if.sv
// Signal bundle for the ejector port list; TCNI_RX is the ejector-side view.
interface ITcniRx #(
    parameter int FLIT_WIDTH = tcni_pkg::FLIT_W
);
    logic                       clock_in;
    logic                       reset_in;
    logic [FLIT_WIDTH-1:0]      flit_in;
    logic                       rx_in;
    logic                       credit_out;
    tcni_pkg::memword_t         data_out;
    tcni_pkg::memword_t         addr_out;
    logic [3:0]                 wb_out;
    tcni_pkg::memoffset_t       data_location_in;
    tcni_pkg::memword_t         time_in;
    logic                       ack_in;
    tcni_pkg::memword_t         arrival_time_out;
    tcni_pkg::memword_t         latency_out;
    logic [2:0]                 status;

    modport TCNI_RX (
        input  clock_in, reset_in, flit_in, rx_in, data_location_in, time_in, ack_in,
        output credit_out, data_out, addr_out, wb_out, arrival_time_out, latency_out, status
    );
endinterface

// File: rtl/tcni_flit_packer.sv
// Pairs accepted flits into memory words; emits one registered write (index, data, enables) per word.
module tcni_flit_packer
    import tcni_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic                    push_full_i,
    input  logic                    push_half_i,
    input  logic [FLIT_WIDTH-1:0]   flit_i,
    output logic [29:0]             word_idx_o,
    output logic [2*FLIT_WIDTH-1:0] data_o,
    output logic [3:0]              be_o
);

    logic [FLIT_WIDTH-1:0]   low_q, low_d;
    logic [29:0]             next_idx_q, next_idx_d;
    logic [29:0]             word_idx_q, word_idx_d;
    logic [2*FLIT_WIDTH-1:0] data_q, data_d;
    logic [3:0]              be_q, be_d;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        low_d      = low_q;
        next_idx_d = next_idx_q;
        word_idx_d = word_idx_q;
        data_d     = data_q;
        be_d       = WB_NONE;

        if (clear_i) next_idx_d = '0;
        if (load_i)  low_d      = flit_i;

        if (push_full_i) begin
            data_d     = {flit_i, low_q};
            be_d       = WB_FULL;
            word_idx_d = next_idx_q;
            next_idx_d = next_idx_q + 30'd1;
        end else if (push_half_i) begin
            data_d     = {{FLIT_WIDTH{1'b0}}, flit_i};
            be_d       = WB_LOW;
            word_idx_d = next_idx_q;
            next_idx_d = next_idx_q + 30'd1;
        end
    end

    // NOTE: registers update with <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            low_q      <= '0;
            next_idx_q <= '0;
            word_idx_q <= '0;
            data_q     <= '0;
            be_q       <= WB_NONE;
        end else begin
            low_q      <= low_d;
            next_idx_q <= next_idx_d;
            word_idx_q <= word_idx_d;
            data_q     <= data_d;
            be_q       <= be_d;
        end
    end

    assign word_idx_o = word_idx_q;
    assign data_o     = data_q;
    assign be_o       = be_q;

endmodule

// File: rtl/tcni_ejector.sv
// Receives Hermes packets from the router local port and writes them to the MMIO-programmed buffer,
// timestamping header and last flit; holds credit low until software acknowledges the packet.
module tcni_ejector
    import tcni_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_W,
    parameter int MAX_FLITS  = 64
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  rx_in,
    output logic                  credit_out,
    output memword_t              data_out,
    output memword_t              addr_out,
    output logic [3:0]            wb_out,
    input  memoffset_t            data_location_in,
    input  memword_t              time_in,
    input  logic                  ack_in,
    output memword_t              arrival_time_out,
    output memword_t              latency_out,
    output logic [2:0]            status
);

    localparam logic [31:0] MAX_CNT  = 32'(MAX_FLITS);
    localparam logic [31:0] MAX_LAST = 32'(MAX_FLITS - 1);

    ej_state_e             state_q, state_d;
    logic                  credit_q, credit_d;
    logic [FLIT_WIDTH-1:0] size_q, size_d;
    logic [31:0]           pay_idx_q, pay_idx_d;
    memoffset_t            base_q, base_d;
    memword_t              arr_q, arr_d;
    memword_t              lat_q, lat_d;
    logic                  ovf_q, ovf_d;

    logic        accept, hdr_acc, size_acc, pay_acc, last_acc;
    logic        in_range, is_last, even_idx;
    logic [29:0] word_idx;

    assign accept   = rx_in && credit_q;
    assign in_range = pay_idx_q < MAX_CNT;
    assign is_last  = pay_idx_q == (32'(size_q) - 32'd1);
    assign even_idx = !pay_idx_q[0];

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        pay_idx_d = pay_idx_q;
        base_d    = base_q;
        arr_d     = arr_q;
        lat_d     = lat_q;
        ovf_d     = ovf_q;
        hdr_acc   = 1'b0;
        size_acc  = 1'b0;
        pay_acc   = 1'b0;
        last_acc  = 1'b0;

        unique case (state_q)
            IDLE: if (accept) begin
                hdr_acc = 1'b1;
                base_d  = data_location_in;
                arr_d   = time_in;
                state_d = SIZE;
            end
            SIZE: if (accept) begin
                size_acc  = 1'b1;
                size_d    = flit_in;
                pay_idx_d = '0;
                if (flit_in == '0) begin
                    last_acc = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (accept) begin
                pay_acc   = 1'b1;
                pay_idx_d = pay_idx_q + 32'd1;
                if (!in_range) ovf_d = 1'b1;
                if (is_last) begin
                    last_acc = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: if (ack_in) begin
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (last_acc) lat_d = time_in - arr_q;
        // Credit is registered from the next state so no flit can land in the completing cycle.
        credit_d = (state_d != DONE);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            credit_q  <= 1'b1;
            size_q    <= '0;
            pay_idx_q <= '0;
            base_q    <= '0;
            arr_q     <= '0;
            lat_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            size_q    <= size_d;
            pay_idx_q <= pay_idx_d;
            base_q    <= base_d;
            arr_q     <= arr_d;
            lat_q     <= lat_d;
            ovf_q     <= ovf_d;
        end
    end

    tcni_flit_packer #(
        .FLIT_WIDTH (FLIT_WIDTH)
    ) u_packer (
        .clk_i       (clock_in),
        .rst_i       (reset_in),
        .clear_i     (hdr_acc),
        .load_i      (hdr_acc || (pay_acc && in_range && even_idx)),
        .push_full_i (size_acc || (pay_acc && in_range && !even_idx)),
        .push_half_i (pay_acc && in_range && even_idx && (is_last || pay_idx_q == MAX_LAST)),
        .flit_i      (flit_in),
        .word_idx_o  (word_idx),
        .data_o      (data_out),
        .be_o        (wb_out)
    );

    assign addr_out         = base_q + {word_idx, 2'b00};
    assign credit_out       = credit_q;
    assign arrival_time_out = arr_q;
    assign latency_out      = lat_q;

    always_comb begin
        status          = '0;
        status[ST_BUSY] = (state_q == SIZE) || (state_q == PAYLOAD);
        status[ST_DONE] = (state_q == DONE);
        status[ST_OVF]  = ovf_q;
    end

endmodule

// File: tb/tb_tcni_ejector.sv
// Randomized scoreboard bench for tcni_ejector: the driver pushes expected writes and done reports,
// a negedge monitor pops and compares them whenever the DUT writes or raises done.
`timescale 1ns/1ps
module tb_tcni_ejector;
    import tcni_pkg::*;

    localparam int MAXF = 4;

    typedef logic [15:0] fq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int unsigned cyc;
    } wr_t;
    typedef struct {
        int unsigned cyc;
        logic [31:0] arr;
        logic [31:0] lat;
        logic [2:0]  st;
    } done_t;

    ITcniRx #(.FLIT_WIDTH(16)) bus ();

    tcni_ejector #(.FLIT_WIDTH(16), .MAX_FLITS(MAXF)) dut (
        .clock_in         (bus.clock_in),
        .reset_in         (bus.reset_in),
        .flit_in          (bus.flit_in),
        .rx_in            (bus.rx_in),
        .credit_out       (bus.credit_out),
        .data_out         (bus.data_out),
        .addr_out         (bus.addr_out),
        .wb_out           (bus.wb_out),
        .data_location_in (bus.data_location_in),
        .time_in          (bus.time_in),
        .ack_in           (bus.ack_in),
        .arrival_time_out (bus.arrival_time_out),
        .latency_out      (bus.latency_out),
        .status           (bus.status)
    );

    wr_t         wq[$];
    done_t       dq[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        prev_done = 1'b0;
    int unsigned ack_cnt = 0;

    initial begin
        bus.clock_in = 1'b0;
        forever #5 bus.clock_in = ~bus.clock_in;
    end

    always @(posedge bus.clock_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic fail_stop(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
        summary_and_finish();
    endtask

    // Monitor: pops expectations when the DUT writes or raises done.
    always @(negedge bus.clock_in) begin
        wr_t   w;
        done_t d;
        check("credit_vs_done", 32'(bus.credit_out), 32'(!bus.status[1]));
        if (bus.wb_out != 4'b0000) begin
            if (wq.size() == 0) begin
                check("unexpected_write_addr", bus.addr_out, 32'hxxxxxxxx);
            end else begin
                w = wq.pop_front();
                check("wr_cycle", cyc, w.cyc);
                check("wr_addr", bus.addr_out, w.addr);
                check("wr_data", bus.data_out, w.data);
                check("wr_be", 32'(bus.wb_out), 32'(w.be));
            end
        end
        if (bus.status[1] && !prev_done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 32'(bus.status), 32'hxxxxxxxx);
            end else begin
                d = dq.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("arrival", bus.arrival_time_out, d.arr);
                check("latency", bus.latency_out, d.lat);
                check("done_status", 32'(bus.status), 32'(d.st));
            end
        end
        prev_done = bus.status[1];
    end

    // Software model: acknowledges done after a random delay, with occasional stray acks elsewhere.
    initial begin
        bus.ack_in = 1'b0;
        forever begin
            @(negedge bus.clock_in);
            if (bus.ack_in) begin
                bus.ack_in = 1'b0;
            end else if (!bus.status[1]) begin
                ack_cnt = $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) bus.ack_in = 1'b1;
            end else if (ack_cnt == 0) begin
                bus.ack_in = 1'b1;
            end else begin
                ack_cnt--;
            end
        end
    end

    task automatic step();
        @(negedge bus.clock_in);
        bus.time_in = bus.time_in + 32'd1;
        bus.rx_in   = 1'b0;
    endtask

    task automatic idle(input int unsigned k);
        repeat (k) step();
    endtask

    task automatic send_flit(input logic [15:0] f, output logic [31:0] t, output int unsigned stamp);
        for (int n = 0; n < 200; n++) begin
            step();
            bus.flit_in = f;
            bus.rx_in   = 1'b1;
            if (bus.credit_out) begin
                t     = bus.time_in;
                stamp = cyc + 1;
                return;
            end
        end
        fail_stop("credit_timeout");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100; n++) begin
            step();
            if (bus.credit_out && !bus.status[1]) return;
        end
        fail_stop("idle_timeout");
    endtask

    // Reference model: expected memory image and done report derived from the packet contents.
    task automatic send_packet(input logic [31:0] base, input logic [15:0] hdr, input fq_t pl,
                               input bit gaps);
        logic [31:0] t, arr, wa;
        int unsigned st;
        int n = pl.size();
        bus.data_location_in = base;
        send_flit(hdr, t, st);
        arr = t;
        if (gaps) idle($urandom_range(0, 1));
        send_flit(16'(n), t, st);
        wq.push_back('{base, {16'(n), hdr}, 4'b1111, st});
        if (n == 0) dq.push_back('{st, arr, t - arr, 3'b010});
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_flit(pl[i], t, st);
            wa = base + 32'(4 * (i / 2 + 1));
            if (i < MAXF) begin
                if (i % 2 == 1)
                    wq.push_back('{wa, {pl[i], pl[i-1]}, 4'b1111, st});
                else if (i == n - 1 || i == MAXF - 1)
                    wq.push_back('{wa, {16'h0000, pl[i]}, 4'b0011, st});
            end
            if (i == n - 1) dq.push_back('{st, arr, t - arr, (n > MAXF) ? 3'b110 : 3'b010});
        end
    endtask

    function automatic fq_t rand_payload(input int n);
        fq_t q;
        for (int i = 0; i < n; i++) q.push_back(16'($urandom));
        return q;
    endfunction

    initial begin
        fq_t         p;
        fq_t         none;
        logic [31:0] t, base;
        int unsigned st;

        bus.reset_in         = 1'b1;
        bus.rx_in            = 1'b0;
        bus.flit_in          = '0;
        bus.time_in          = '0;
        bus.data_location_in = '0;
        idle(2);
        check("rst_credit", 32'(bus.credit_out), 32'd1);
        check("rst_data", bus.data_out, 32'd0);
        check("rst_addr", bus.addr_out, 32'd0);
        check("rst_wb", 32'(bus.wb_out), 32'd0);
        check("rst_status", 32'(bus.status), 32'd0);
        check("rst_arrival", bus.arrival_time_out, 32'd0);
        check("rst_latency", bus.latency_out, 32'd0);
        bus.reset_in = 1'b0;
        idle(2);

        // Three-flit payload, back-to-back from time 100.
        wait_idle();
        bus.time_in = 32'd99;
        p = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_packet(32'h100, 16'h0011, p, 1'b0);
        step();
        check("t1_status", 32'(bus.status), 32'b010);
        check("t1_arrival", bus.arrival_time_out, 32'd100);
        check("t1_latency", bus.latency_out, 32'd4);

        // Empty payload.
        wait_idle();
        send_packet(32'h200, 16'h0022, none, 1'b0);
        step();
        check("t2_status", 32'(bus.status), 32'b010);
        check("t2_latency", bus.latency_out, 32'd1);

        // Overflow: six payload flits into a four-flit buffer.
        wait_idle();
        send_packet(32'h300, 16'h0033, rand_payload(6), 1'b1);
        step();
        check("t3_status", 32'(bus.status), 32'b110);
        wait_idle();
        check("t3_status_after_ack", 32'(bus.status), 32'b000);

        // Timestamp wrap.
        wait_idle();
        bus.time_in = 32'hFFFF_FFFD;
        send_packet(32'h400, 16'h0055, rand_payload(3), 1'b0);
        step();
        check("t5_arrival", bus.arrival_time_out, 32'hFFFF_FFFE);
        check("t5_latency", bus.latency_out, 32'd4);

        // Reset after two payload flits of a size-4 packet.
        wait_idle();
        p = rand_payload(4);
        bus.data_location_in = 32'h600;
        send_flit(16'h0066, t, st);
        send_flit(16'd4, t, st);
        wq.push_back('{32'h600, {16'd4, 16'h0066}, 4'b1111, st});
        send_flit(p[0], t, st);
        send_flit(p[1], t, st);
        wq.push_back('{32'h604, {p[1], p[0]}, 4'b1111, st});
        step();
        bus.reset_in = 1'b1;
        step();
        bus.reset_in = 1'b0;
        check("mr_credit", 32'(bus.credit_out), 32'd1);
        check("mr_wb", 32'(bus.wb_out), 32'd0);
        check("mr_data", bus.data_out, 32'd0);
        check("mr_addr", bus.addr_out, 32'd0);
        check("mr_status", 32'(bus.status), 32'd0);
        check("mr_arrival", bus.arrival_time_out, 32'd0);
        check("mr_latency", bus.latency_out, 32'd0);
        send_packet(32'h700, 16'h0077, rand_payload(2), 1'b0);

        // Random packets issued back to back, so each header waits out the previous DONE.
        for (int k = 0; k < 25; k++) begin
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            base[1:0] = 2'b00;
            send_packet(base, 16'($urandom), rand_payload($urandom_range(0, 9)), 1'b1);
        end

        wait_idle();
        idle(4);
        check("writes_outstanding", 32'(wq.size()), 32'd0);
        check("dones_outstanding", 32'(dq.size()), 32'd0);
        summary_and_finish();
    end

endmodule

// File: doc/tcni_ejector.md
# tcni_ejector

Receive-side counterpart of the TCNI packet injector. It accepts Hermes-style packets flit by flit from the router local port and writes each packet into processor memory at the MMIO-programmed buffer location. It timestamps header arrival and last-flit arrival, and reports status to the MMIO block. The network is back-pressured with credit until software acknowledges the buffered packet.

## Interface
Parameters:
- FLIT_WIDTH, 16: flit width in bits; two flits are packed per memword.
- MAX_FLITS, 64: buffer payload capacity in flits; flits beyond this count are consumed but not written.

Ports (memword = 32 bits; memoffset from the testbench package):
- clock_in  input  1  single clock; all logic on the rising edge.
- reset_in  input  1  reset; synchronous, active-high.
- flit_in  input  FLIT_WIDTH  flit from the router.
- rx_in  input  1  flit_in is valid.
- credit_out  output  1  ejector can accept a flit this cycle.
- data_out  output  memword  memory write data.
- addr_out  output  memword  memory byte address.
- wb_out  output  4  byte write enables; 0 means no write.
- data_location_in  input  memoffset  buffer base byte address; word-aligned.
- time_in  input  memword  free-running cycle counter.
- ack_in  input  1  software has consumed the buffered packet.
- arrival_time_out  output  memword  time_in value when the header was accepted.
- latency_out  output  memword  last-flit time minus header time, modulo 2^32.
- status  output  3  [0] busy, [1] done, [2] overflow.

## Operation
- A flit is accepted in a cycle where rx_in && credit_out.
- Packet format: header flit, size flit (N = payload count), then N payload flits.
- States and transitions:
  - IDLE: goes to SIZE on header accept.
  - SIZE: goes to PAYLOAD on size accept, or to DONE if N = 0.
  - PAYLOAD: goes to DONE on accept of the Nth payload flit.
  - DONE: goes to IDLE on ack_in.
- credit_out = 1 in IDLE, SIZE and PAYLOAD; 0 in DONE.
- On header accept, data_location_in and time_in are latched as base and arrival_time_out.
- Memory layout:
  - Word 0 at base = {size, header}.
  - Word k ≥ 1 at base+4k = {payload[2k−1], payload[2k−2]}, with the earlier flit in bits [15:0].
  - An odd final payload flit is written to [15:0] with bits [31:16] = 0 and wb_out = 4'b0011.
  - All other writes use wb_out = 4'b1111.
- Address arithmetic: base + 4k, zero-extended and wrapping modulo 2^32.
- Overflow: payload flits with index ≥ MAX_FLITS are still accepted (credit unchanged) but not written, and status[2] is set.
  - MAX_FLITS odd: the last in-range flit is written as a half word.
- latency_out is computed at the last accepted flit (the size flit when N = 0) and is wrap-safe unsigned subtraction.
- status bits:
  - status[0] = 1 in SIZE and PAYLOAD.
  - status[1] = 1 in DONE.
  - status[2] is sticky until ack_in in DONE.
- ack_in outside DONE is ignored.
- Reset mid-packet: all state is discarded and no partial write is issued. The next accepted flit is treated as a header, so the network must be reset together with the ejector.

## Timing
- Reset values: credit_out 1, data_out 0, addr_out 0, wb_out 0, status 0, arrival_time_out 0, latency_out 0; state IDLE.
- Writes are registered: a write appears on addr_out/data_out/wb_out exactly one cycle after the accept that completes its word. Word 0 completes on size accept.
- wb_out is nonzero for exactly one cycle per word.
- status[1] rises in the same cycle as the final write, or one cycle after size accept when N = 0. credit_out falls in that same cycle.
- A flit accepted in the completing cycle is impossible, because credit_out is registered from the next state.
- ack_in sampled high in DONE → IDLE next cycle: status = 0 and credit_out = 1.
- Back-to-back flits sustain one flit per cycle. Minimum gap between packets is 1 cycle (ack) after done.

## Structure
- tcni_pkg holds:
  - flit_t;
  - the state enum (IDLE, SIZE, PAYLOAD, DONE);
  - status bit index constants (ST_BUSY=0, ST_DONE=1, ST_OVF=2);
  - WB_FULL = 4'b1111 and WB_LOW = 4'b0011.
- Sub-module tcni_flit_packer: pairs flits into memwords and produces word index, data and byte enables. The FSM, timestamps and MMIO outputs stay in tcni_ejector.
- The port list is exposed through an ITcniRx interface with modport TCNI_RX.

## Test plan
- Base 0x100, header 0x0011, size 3, payload 0xAAAA/0xBBBB/0xCCCC back-to-back starting at time 100 → writes 0x100 = 0x00030011 (1111), 0x104 = 0xBBBBAAAA (1111), 0x108 = 0x0000CCCC (0011); arrival_time_out = 100; latency_out = 4; status = 3'b010.
- Size 0 packet → single write at base = {0x0000, header}; done one cycle after size accept; latency_out = 1.
- MAX_FLITS = 4, size 6 → exactly 3 writes; all 8 flits accepted; status = 3'b110; ack clears status to 0.
- Second packet presented while in DONE → credit_out = 0 and no accepts until ack; the packet is then received intact at the new base.
- Header at time 0xFFFFFFFE, 4 more flits one per cycle → latency_out = 4 across the wrap.
- reset_in asserted after two payload flits of size 4 → no further writes; all outputs at reset values next cycle; the next flit is parsed as a header.
